fifo_ms_rr: RTL and testbench

Parametrised multi-stream FIFO: one tagged write port feeding FLUX independent per-stream queues, drained through a single valid/ready output port by a round-robin arbiter. It is the next generation of the multi-stream FIFO in the dataflow fabric. It adds the following over the previous block:
- per-stream occupancy and almost-full flags
- per-stream flush
- a write-error pulse
- a registered, back-pressurable output stage

---
 rtl/fifo_ms_rr_pkg.sv | 27 ++
 rtl/fifo_ms_rr_if.sv | 36 +++
 rtl/fifo_ms_rr_arbiter.sv | 42 ++++
 rtl/fifo_ms_rr.sv | 111 +++++++++++
 tb/tb_fifo_ms_rr.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ms_rr_pkg.sv
// Shared definitions for the multi-stream round-robin FIFO.
// Holds the default parameter values, the width helpers used to size the
// tag and count fields, and the packed {tag, data} word at default sizing.
package fifo_ms_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 4;
    localparam int FLUX_DEF       = 2;

    // Width of the stream tag; a single stream still gets one bit.
    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    // Width of an occupancy counter, which must reach DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int TAG_W_DEF = tag_w(FLUX_DEF);

    typedef struct packed {
        logic [TAG_W_DEF-1:0]      tag;
        logic [DATA_WIDTH_DEF-1:0] data;
    } word_t;

endpackage

// File: rtl/fifo_ms_rr_if.sv
// Bus bundle for fifo_ms_rr.
// slave  : the FIFO side (takes writes, flush, dout_ready; drives status/dout)
// master : producer/consumer side
//   din/write/flush    tagged write port and per-stream clear
//   full/almost_full/empty/count/wr_err  per-stream status
//   dout/dout_valid/dout_ready           registered output handshake
interface fifo_ms_rr_if #(
    parameter int DATA_WIDTH = fifo_ms_pkg::DATA_WIDTH_DEF,
    parameter int DEPTH      = fifo_ms_pkg::DEPTH_DEF,
    parameter int FLUX       = fifo_ms_pkg::FLUX_DEF
);
    localparam int TAG_W = fifo_ms_pkg::tag_w(FLUX);
    localparam int CNT_W = fifo_ms_pkg::cnt_w(DEPTH);

    logic [TAG_W+DATA_WIDTH-1:0] din;
    logic                        write;
    logic [FLUX-1:0]             flush;
    logic [FLUX-1:0]             full;
    logic [FLUX-1:0]             almost_full;
    logic [FLUX-1:0]             empty;
    logic [FLUX*CNT_W-1:0]       count;
    logic                        wr_err;
    logic [TAG_W+DATA_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        dout_ready;

    modport slave (
        input  din, write, flush, dout_ready,
        output full, almost_full, empty, count, wr_err, dout, dout_valid
    );

    modport master (
        output din, write, flush, dout_ready,
        input  full, almost_full, empty, count, wr_err, dout, dout_valid
    );
endinterface

// File: rtl/fifo_ms_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   req     : eligibility vector
//   adv     : a grant is being taken this cycle; pointer moves past it
//   grant   : one-hot grant, first requester at or after the pointer
//   gnt_idx : binary index of the granted requester
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                gnt_idx         = IW'(idx);
                found           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/fifo_ms_rr.sv
// Multi-stream FIFO: one tagged write port feeding FLUX independent queues,
// drained round-robin into a registered, back-pressurable output word.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fifo_ms_rr_if.slave (write port, flush, status, output handshake)
// All status flags come from registered counts, so a pop in the same cycle
// never frees room for a write to that stream.
module fifo_ms_rr
    import fifo_ms_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FLUX       = FLUX_DEF,
    parameter int AFULL_THR  = DEPTH - 1
) (
    input logic         clk,
    input logic         rst,
    fifo_ms_rr_if.slave bus
);
    localparam int TAG_W = tag_w(FLUX);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]        mem [FLUX][DEPTH];
    logic [FLUX-1:0][PTR_W-1:0]   head, tail;
    logic [FLUX-1:0][CNT_W-1:0]   cnt;
    logic [FLUX-1:0]              full_s, empty_s, af_s, hit, push, pop, elig, grant;
    logic [TAG_W-1:0]             wr_tag, gnt_idx;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         load, wr_err_q, dout_valid_q;
    logic [TAG_W+DATA_WIDTH-1:0]  dout_q;

    assign {wr_tag, wr_data} = bus.din;

    for (genvar i = 0; i < FLUX; i++) begin : g_stream
        assign full_s[i]  = (cnt[i] == CNT_W'(DEPTH));
        assign empty_s[i] = (cnt[i] == '0);
        assign af_s[i]    = (cnt[i] >= CNT_W'(AFULL_THR));
        // Tags beyond FLUX-1 match no stream and are dropped.
        assign hit[i]     = bus.write && (wr_tag == TAG_W'(i));
        assign push[i]    = hit[i] && !full_s[i] && !bus.flush[i];
        // A stream being flushed must not hand out its stale head word.
        assign elig[i]    = !empty_s[i] && !bus.flush[i];
        assign pop[i]     = load && grant[i];
    end

    assign load = (!dout_valid_q || bus.dout_ready) && (|elig);

    rr_arbiter #(.N(FLUX), .IW(TAG_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .adv     (load),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                if (bus.flush[i]) begin
                    head[i] <= '0;
                    tail[i] <= '0;
                    cnt[i]  <= '0;
                end else begin
                    if (push[i]) tail[i] <= tail[i] + 1'b1;
                    if (pop[i])  head[i] <= head[i] + 1'b1;
                    case ({push[i], pop[i]})
                        2'b10:   cnt[i] <= cnt[i] + 1'b1;
                        2'b01:   cnt[i] <= cnt[i] - 1'b1;
                        default: cnt[i] <= cnt[i];
                    endcase
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FLUX; i++)
            if (push[i]) mem[i][tail[i]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            // Flush wins over a write, so it suppresses the error too.
            wr_err_q <= |(hit & full_s & ~bus.flush);
            if (load) begin
                dout_q       <= {gnt_idx, mem[gnt_idx][head[gnt_idx]]};
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.almost_full = af_s;
    assign bus.count       = cnt;
    assign bus.wr_err      = wr_err_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
endmodule

// File: tb/tb_fifo_ms_rr.sv
// Self-checking bench for fifo_ms_rr at DATA_WIDTH=8, DEPTH=4, FLUX=2.
module tb_fifo_ms_rr;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int FLUX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ms_rr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX)) bus ();

    fifo_ms_rr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX), .AFULL_THR(DEPTH - 1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    typedef struct {
        logic       wr;
        logic [8:0] din;
        logic [2:0] exp_cnt0;
        logic [1:0] exp_full;
        logic [1:0] exp_af;
        logic       exp_err;
        logic       exp_dv;
        logic [8:0] exp_dout;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic tag, input logic [7:0] data);
        bus.write = 1'b1;
        bus.din   = {tag, data};
    endtask

    task automatic wait_drain(input string nm, input int max);
        int k = 0;
        while ((sb.size() != 0 || bus.dout_valid) && k < max) begin
            tick();
            k++;
        end
        check({nm, "_left"}, 32'(sb.size()), 32'd0);
        check({nm, "_dv"}, 32'(bus.dout_valid), 32'd0);
    endtask

    // Scoreboard: a handshake seen before the edge is compared with the
    // oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", bus.dout);
            end else begin
                mon_exp = sb.pop_front();
                check("dout_order", 32'(bus.dout), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.din = '0; bus.write = 1'b0; bus.flush = '0; bus.dout_ready = 1'b0;

        //                 wr   din      cnt0  full   af     err  dv   dout
        vt[0] = '{1'b1, 9'h001, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 9'h1A5};
        vt[1] = '{1'b1, 9'h002, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1, 9'h001};
        vt[2] = '{1'b1, 9'h003, 3'd2, 2'b00, 2'b00, 1'b0, 1'b1, 9'h001};
        vt[3] = '{1'b1, 9'h004, 3'd3, 2'b00, 2'b01, 1'b0, 1'b1, 9'h001};
        vt[4] = '{1'b1, 9'h005, 3'd4, 2'b01, 2'b01, 1'b0, 1'b1, 9'h001};
        vt[5] = '{1'b1, 9'h006, 3'd4, 2'b01, 2'b01, 1'b1, 1'b1, 9'h001};
        vt[6] = '{1'b0, 9'h000, 3'd4, 2'b01, 2'b01, 1'b0, 1'b1, 9'h001};

        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_dv", 32'(bus.dout_valid), 32'd0);
        check("rst_err", 32'(bus.wr_err), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'h3);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_af", 32'(bus.almost_full), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);

        // Single word latency
        bus.dout_ready = 1'b1;
        wr(1'b1, 8'hA5);
        sb.push_back(9'h1A5);
        tick();
        bus.write = 1'b0;
        check("lat_empty_k", 32'(bus.empty), 32'h1);
        check("lat_dv_k", 32'(bus.dout_valid), 32'd0);
        tick();
        check("lat_dv_k1", 32'(bus.dout_valid), 32'd1);
        check("lat_dout_k1", 32'(bus.dout), 32'h1A5);
        check("lat_empty_k1", 32'(bus.empty), 32'h3);
        tick();
        check("lat_dv_fall", 32'(bus.dout_valid), 32'd0);
        check("lat_dout_hold", 32'(bus.dout), 32'h1A5);

        // Fill stream 0 with the consumer stalled
        bus.dout_ready = 1'b0;
        for (int r = 0; r < 7; r++) begin
            bus.write = vt[r].wr;
            bus.din   = vt[r].din;
            tick();
            check($sformatf("fill%0d_cnt0", r), 32'(bus.count[2:0]), 32'(vt[r].exp_cnt0));
            check($sformatf("fill%0d_full", r), 32'(bus.full), 32'(vt[r].exp_full));
            check($sformatf("fill%0d_af", r), 32'(bus.almost_full), 32'(vt[r].exp_af));
            check($sformatf("fill%0d_err", r), 32'(bus.wr_err), 32'(vt[r].exp_err));
            check($sformatf("fill%0d_dv", r), 32'(bus.dout_valid), 32'(vt[r].exp_dv));
            check($sformatf("fill%0d_dout", r), 32'(bus.dout), 32'(vt[r].exp_dout));
        end
        // Write to a full stream while it is popped: still rejected
        for (int d = 1; d <= 5; d++) sb.push_back(9'(d));
        bus.dout_ready = 1'b1;
        wr(1'b0, 8'h07);
        tick();
        bus.write = 1'b0;
        check("full_pop_err", 32'(bus.wr_err), 32'd1);
        check("full_pop_cnt0", 32'(bus.count[2:0]), 32'd3);
        wait_drain("drain_fill", 20);

        // Round-robin alternation
        bus.dout_ready = 1'b0;
        wr(1'b0, 8'h10); tick();
        wr(1'b0, 8'h11); tick();
        wr(1'b0, 8'h12); tick();
        wr(1'b0, 8'h13); tick();
        wr(1'b1, 8'h20); tick();
        wr(1'b1, 8'h21); tick();
        wr(1'b1, 8'h22); tick();
        bus.write = 1'b0;
        check("rr_cnt", 32'(bus.count), 32'h1B);
        check("rr_head", 32'(bus.dout), 32'h010);
        sb.push_back(9'h010); sb.push_back(9'h120); sb.push_back(9'h011);
        sb.push_back(9'h121); sb.push_back(9'h012); sb.push_back(9'h122);
        sb.push_back(9'h013);
        bus.dout_ready = 1'b1;
        n = 0;
        while (bus.dout_valid && n < 20) begin
            tick();
            n++;
        end
        check("rr_burst_cycles", 32'(n), 32'd7);
        check("rr_left", 32'(sb.size()), 32'd0);

        // Stall with writes continuing
        bus.dout_ready = 1'b0;
        wr(1'b1, 8'h30); tick();
        wr(1'b0, 8'h40); tick();
        check("stall_dout0", 32'(bus.dout), 32'h130);
        wr(1'b1, 8'h31); tick();
        check("stall_dout1", 32'(bus.dout), 32'h130);
        wr(1'b0, 8'h41); tick();
        check("stall_dout2", 32'(bus.dout), 32'h130);
        wr(1'b1, 8'h32); tick();
        bus.write = 1'b0;
        check("stall_dout3", 32'(bus.dout), 32'h130);
        check("stall_dv", 32'(bus.dout_valid), 32'd1);
        sb.push_back(9'h130); sb.push_back(9'h040); sb.push_back(9'h131);
        sb.push_back(9'h041); sb.push_back(9'h132);
        bus.dout_ready = 1'b1;
        wait_drain("drain_stall", 20);

        // Flush with a same-cycle write
        bus.dout_ready = 1'b0;
        wr(1'b0, 8'h50); tick();
        wr(1'b0, 8'h51); tick();
        wr(1'b0, 8'h52); tick();
        wr(1'b0, 8'h53); tick();
        check("flush_pre_cnt0", 32'(bus.count[2:0]), 32'd3);
        wr(1'b0, 8'h54);
        bus.flush = 2'b01;
        tick();
        bus.write = 1'b0;
        bus.flush = 2'b00;
        check("flush_cnt0", 32'(bus.count[2:0]), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'h3);
        check("flush_err", 32'(bus.wr_err), 32'd0);
        check("flush_dout_kept", 32'(bus.dout), 32'h050);
        sb.push_back(9'h050);
        bus.dout_ready = 1'b1;
        wait_drain("drain_flush", 10);
        tick(); tick(); tick();
        check("flush_after_dv", 32'(bus.dout_valid), 32'd0);

        // Asynchronous reset mid-stream
        bus.dout_ready = 1'b0;
        wr(1'b0, 8'h70); tick();
        wr(1'b1, 8'h60); tick();
        wr(1'b1, 8'h61); tick();
        wr(1'b1, 8'h62); tick();
        wr(1'b1, 8'h63); tick();
        wr(1'b1, 8'h64); tick();
        bus.write = 1'b0;
        check("pre_rst_err", 32'(bus.wr_err), 32'd1);
        check("pre_rst_full", 32'(bus.full), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dv", 32'(bus.dout_valid), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_err", 32'(bus.wr_err), 32'd0);
        check("arst_empty", 32'(bus.empty), 32'h3);
        check("arst_dout", 32'(bus.dout), 32'd0);
        tick();
        rst = 1'b0;
        wr(1'b0, 8'h90); tick();
        wr(1'b1, 8'h91); tick();
        bus.write = 1'b0;
        check("post_rst_first", 32'(bus.dout), 32'h090);
        sb.push_back(9'h090); sb.push_back(9'h191);
        bus.dout_ready = 1'b1;
        wait_drain("drain_rst", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
